// File: rtl/kamacore_hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard.
//   KC_REG_ADDR_WIDTH : architectural register address width
//   pend_t            : pending-write count as seen by the top (wide enough for 7)
//   flush_state_t     : branch flush sequencer states
//   X0_ADDR           : hardwired-zero register, never tracked
package kamacore_hazard_scoreboard_pkg;

  localparam int KC_REG_ADDR_WIDTH = 5;

  // Upper bound of MAX_PENDING is 7, so three bits always hold any count.
  localparam int PEND_W = 3;
  typedef logic [PEND_W-1:0] pend_t;

  typedef enum logic {
    FLUSH_IDLE   = 1'b0,
    FLUSH_ACTIVE = 1'b1
  } flush_state_t;

  localparam int X0_ADDR = 0;

  function automatic int pend_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/kamacore_pending_counter.sv
// Saturating count of in-flight writes to one architectural register.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : an issuing instruction targets this register
//   dec       : writeback targets this register (ignored when count is 0)
//   count     : current number of in-flight writes
//   underflow : writeback arrived with nothing outstanding
module kamacore_pending_counter #(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  logic dec_eff;
  logic at_max;

  assign dec_eff   = dec & (count != '0);
  assign underflow = dec & (count == '0);
  assign at_max    = (count == CNT_W'(MAX_PENDING));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec_eff) begin
      // Issue logic already blocks this case; saturate anyway so the count
      // can never wrap.
      if (!at_max) begin
        count <= count + CNT_W'(1);
      end
    end else if (dec_eff && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/kamacore_hazard_scoreboard.sv
// Decode-stage issue controller: tracks in-flight register writes, stalls
// decode on read-after-write and pending-count overflow, sequences branch
// flushes of the IF/ID and ID/EX buffers.
//   clk, rst                     : clock, synchronous active-high reset
//   id_valid, id_rs1_a/_used,
//   id_rs2_a/_used, id_rd_a/_we  : decoded instruction operands
//   writeback_rd_we/_a           : retiring register write
//   branch_valid                 : branch redirect resolved this cycle
//   id_issue                     : instruction advances into ID/EX
//   stall_id                     : hold IF/ID and PC, bubble into ID/EX
//   flush_if_id, flush_id_ex     : invalidate pipeline buffers
//   busy_vector                  : per-register "write outstanding"
//   sb_error                     : sticky writeback-without-pending flag
module kamacore_hazard_scoreboard
  import kamacore_hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = KC_REG_ADDR_WIDTH,
  parameter int MAX_PENDING    = 3,
  parameter int FLUSH_CYCLES   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    id_rs1_a,
  input  logic                         id_rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0]    id_rs2_a,
  input  logic                         id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0]    id_rd_a,
  input  logic                         id_rd_we,
  input  logic                         writeback_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0]    writeback_rd_a,
  input  logic                         branch_valid,
  output logic                         id_issue,
  output logic                         stall_id,
  output logic                         flush_if_id,
  output logic                         flush_id_ex,
  output logic [2**REG_ADDR_WIDTH-1:0] busy_vector,
  output logic                         sb_error
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int CNT_W    = pend_width(MAX_PENDING);
  localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(X0_ADDR);
  localparam pend_t PEND_MAX = pend_t'(MAX_PENDING);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  pend_t               pend [NUM_REGS];
  logic [NUM_REGS-1:0] underflow;

  flush_state_t state, state_next;
  logic [3:0]   flush_cnt, flush_cnt_next;

  logic flushing;
  logic rs1_clear, rs2_clear;
  logic raw, full, hazard;
  logic wb_retires_rd;

  // ---- per-register pending counters ----
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    if (r == X0_ADDR) begin : g_x0
      assign pend[r]      = '0;
      assign underflow[r] = 1'b0;
    end else begin : g_cnt
      localparam logic [REG_ADDR_WIDTH-1:0] ADDR = REG_ADDR_WIDTH'(r);
      logic [CNT_W-1:0] count;
      logic             inc;
      logic             dec;

      assign inc = id_issue & id_rd_we & (id_rd_a == ADDR);
      assign dec = writeback_rd_we & (writeback_rd_a == ADDR);

      kamacore_pending_counter #(
        .MAX_PENDING(MAX_PENDING),
        .CNT_W      (CNT_W)
      ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .dec      (dec),
        .count    (count),
        .underflow(underflow[r])
      );

      assign pend[r] = pend_t'(count);
    end
  end

  // ---- hazard detection (combinational, zero latency) ----
  always_comb begin
    // A final outstanding write retiring this cycle is forwarded by the
    // register file, so it no longer blocks the reader.
    rs1_clear = writeback_rd_we && (writeback_rd_a == id_rs1_a) &&
                (pend[id_rs1_a] == pend_t'(1));
    rs2_clear = writeback_rd_we && (writeback_rd_a == id_rs2_a) &&
                (pend[id_rs2_a] == pend_t'(1));

    raw = (id_rs1_used && (pend[id_rs1_a] != '0) && !rs1_clear) ||
          (id_rs2_used && (pend[id_rs2_a] != '0) && !rs2_clear);

    wb_retires_rd = writeback_rd_we && (writeback_rd_a == id_rd_a) &&
                    (pend[id_rd_a] != '0);
    full = id_rd_we && (id_rd_a != X0) && (pend[id_rd_a] == PEND_MAX) &&
           !wb_retires_rd;

    hazard = raw | full;
  end

  // ---- flush sequencer: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // ---- flush sequencer: next state ----
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      FLUSH_IDLE: begin
        // A one-cycle flush is fully covered by the branch_valid cycle.
        if (branch_valid && (FLUSH_CYCLES > 1)) begin
          state_next     = FLUSH_ACTIVE;
          flush_cnt_next = FLUSH_RELOAD;
        end
      end
      FLUSH_ACTIVE: begin
        if (branch_valid) begin
          flush_cnt_next = FLUSH_RELOAD;
        end else if (flush_cnt <= 4'd1) begin
          state_next     = FLUSH_IDLE;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt - 4'd1;
        end
      end
      default: begin
        state_next     = FLUSH_IDLE;
        flush_cnt_next = '0;
      end
    endcase
  end

  // ---- flush sequencer and issue outputs ----
  always_comb begin
    flushing    = (state == FLUSH_ACTIVE) | branch_valid;
    flush_if_id = flushing;
    flush_id_ex = flushing;
    // Flush wins over stall: a flushed instruction is discarded, not held.
    stall_id    = id_valid & hazard & ~flushing;
    id_issue    = id_valid & ~hazard & ~flushing;
  end

  always_comb begin
    busy_vector = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vector[r] = (pend[r] != '0);
    end
  end

  // ---- sticky error ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_error <= 1'b0;
    end else if (|underflow) begin
      sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kamacore_hazard_scoreboard.sv
// Scoreboard bench for kamacore_hazard_scoreboard: directed scenarios then
// randomized traffic, checked against a count-based reference model.
module tb_kamacore_hazard_scoreboard;

  localparam int AW   = 5;
  localparam int NR   = 32;
  localparam int MAXP = 3;
  localparam int FC   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1_a;
  logic          id_rs1_used;
  logic [AW-1:0] id_rs2_a;
  logic          id_rs2_used;
  logic [AW-1:0] id_rd_a;
  logic          id_rd_we;
  logic          writeback_rd_we;
  logic [AW-1:0] writeback_rd_a;
  logic          branch_valid;
  logic          id_issue;
  logic          stall_id;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic [NR-1:0] busy_vector;
  logic          sb_error;

  always #5 clk = ~clk;

  kamacore_hazard_scoreboard #(
    .REG_ADDR_WIDTH(AW),
    .MAX_PENDING   (MAXP),
    .FLUSH_CYCLES  (FC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs1_a       (id_rs1_a),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_a       (id_rs2_a),
    .id_rs2_used    (id_rs2_used),
    .id_rd_a        (id_rd_a),
    .id_rd_we       (id_rd_we),
    .writeback_rd_we(writeback_rd_we),
    .writeback_rd_a (writeback_rd_a),
    .branch_valid   (branch_valid),
    .id_issue       (id_issue),
    .stall_id       (stall_id),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .busy_vector    (busy_vector),
    .sb_error       (sb_error)
  );

  typedef struct packed {
    bit            issue;
    bit            stall;
    bit            flush;
    bit            err;
    logic [NR-1:0] busy;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: outstanding writes per register, remaining flush cycles
  // after the current one, sticky error.
  int pend_m [NR];
  int flush_left;
  bit err_m;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) pend_m[i] = 0;
    flush_left = 0;
    err_m      = 1'b0;
  endtask

  task automatic chk(input string name, input logic [NR-1:0] act, input logic [NR-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit v,
                      input logic [AW-1:0] a1, input bit u1,
                      input logic [AW-1:0] a2, input bit u2,
                      input logic [AW-1:0] ad, input bit we,
                      input bit wwe, input logic [AW-1:0] wa, input bit br);
    exp_t e;
    bit   fl, blk1, blk2, fullm, haz;
    int   i1, i2, id, iw, old_w;
    @(posedge clk);
    #1;
    rst = r; id_valid = v;
    id_rs1_a = a1; id_rs1_used = u1;
    id_rs2_a = a2; id_rs2_used = u2;
    id_rd_a = ad; id_rd_we = we;
    writeback_rd_we = wwe; writeback_rd_a = wa;
    branch_valid = br;

    i1 = int'(a1); i2 = int'(a2); id = int'(ad); iw = int'(wa);
    fl    = (flush_left > 0) || br;
    blk1  = u1 && i1 != 0 && pend_m[i1] > 0 && !(wwe && iw == i1 && pend_m[i1] == 1);
    blk2  = u2 && i2 != 0 && pend_m[i2] > 0 && !(wwe && iw == i2 && pend_m[i2] == 1);
    fullm = we && id != 0 && pend_m[id] >= MAXP && !(wwe && iw == id);
    haz   = blk1 || blk2 || fullm;

    e.issue = v && !haz && !fl;
    e.stall = v && haz && !fl;
    e.flush = fl;
    e.err   = err_m;
    for (int i = 0; i < NR; i++) e.busy[i] = (pend_m[i] != 0);
    q.push_back(e);

    if (r) begin
      model_reset();
    end else begin
      old_w = pend_m[iw];
      if (e.issue && we && id != 0) pend_m[id]++;
      if (wwe && iw != 0) begin
        if (old_w > 0) pend_m[iw]--;
        else err_m = 1'b1;
      end
      if (br) flush_left = FC - 1;
      else if (flush_left > 0) flush_left--;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a fresh set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_issue",    NR'(id_issue),    NR'(e.issue));
        chk("stall_id",    NR'(stall_id),    NR'(e.stall));
        chk("flush_if_id", NR'(flush_if_id), NR'(e.flush));
        chk("flush_id_ex", NR'(flush_id_ex), NR'(e.flush));
        chk("busy_vector", busy_vector,      e.busy);
        chk("sb_error",    NR'(sb_error),    NR'(e.err));
      end
    end
  end

  logic [AW-1:0] s_a1, s_a2, s_ad, s_wa;
  bit            s_v, s_u1, s_u2, s_we, s_wwe, s_br, s_r, s_errp;

  initial begin
    rst = 1'b1; id_valid = 0; id_rs1_a = '0; id_rs1_used = 0;
    id_rs2_a = '0; id_rs2_used = 0; id_rd_a = '0; id_rd_we = 0;
    writeback_rd_we = 0; writeback_rd_a = '0; branch_valid = 0;
    model_reset();
    repeat (3) @(posedge clk);

    // Reset state, then RAW stall released by same-cycle writeback.
    idle();
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    repeat (3) step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    idle();

    // x0 is never tracked; unused sources never stall.
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);

    // Saturation on register 7.
    repeat (3) step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    idle();

    // Branch flush, then a back-to-back branch extending the window.
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    idle();
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    idle();

    // Flush beats stall; writeback still retires during flush.
    step(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    step(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 9, 1, 0, 0, 1, 9, 0);
    idle();
    idle();

    // Underflow is sticky; reset mid-flush with pending counts clears all.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    idle();
    idle();
    step(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      s_errp = (n > 1250);
      s_v   = ($urandom_range(0, 3) != 0);
      s_a1  = AW'($urandom_range(0, 7));
      s_a2  = AW'($urandom_range(0, 7));
      s_ad  = AW'($urandom_range(0, 7));
      s_u1  = ($urandom_range(0, 2) != 0);
      s_u2  = ($urandom_range(0, 2) != 0);
      s_we  = ($urandom_range(0, 3) != 0);
      s_wa  = AW'($urandom_range(1, 7));
      s_wwe = 1'b0;
      if ($urandom_range(0, 99) < 45) begin
        if (pend_m[int'(s_wa)] > 0 || (s_errp && $urandom_range(0, 9) == 0)) s_wwe = 1'b1;
      end
      s_br = ($urandom_range(0, 14) == 0);
      s_r  = ($urandom_range(0, 249) == 0);
      step(s_r, s_v, s_a1, s_u1, s_a2, s_u2, s_ad, s_we, s_wwe, s_wa, s_br);
    end
    idle();

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 outstanding expectations", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
